// File: rtl/umi_fifo_flex_pkg.sv
// Purpose: shared constants for umi_fifo_flex (chaos LFSR geometry, tap mask, default seed).
// Latency: n/a (package).
// Backpressure: n/a (package).
package umi_fifo_flex_pkg;

  localparam int LFSR_W = 16;

  // Polynomial x^16 + x^14 + x^13 + x^11. The register shifts right, so the
  // taps counted from the output end (16,14,13,11) land on bits 0,2,3,5.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

  localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 16'hACE1;

  // One Fibonacci step: XOR of the tapped bits enters at the MSB.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] state);
    return {^(state & LFSR_TAPS), state[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/umi_fifo_flex_if.sv
// Purpose: one UMI valid/ready channel (cmd, dstaddr, srcaddr, data).
// Latency: n/a (wiring only).
// Backpressure: transfer when valid && ready; the master holds payload while valid && !ready.
// Ports: valid/cmd/dstaddr/srcaddr/data driven by master, ready driven by slave.
interface umi_fifo_flex_if #(
  parameter int DW = 128,
  parameter int AW = 64,
  parameter int CW = 32
);

  logic          valid;
  logic          ready;
  logic [CW-1:0] cmd;
  logic [AW-1:0] dstaddr;
  logic [AW-1:0] srcaddr;
  logic [DW-1:0] data;

  modport master (
    output valid,
    output cmd,
    output dstaddr,
    output srcaddr,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  cmd,
    input  dstaddr,
    input  srcaddr,
    input  data,
    output ready
  );

endinterface

// File: rtl/umi_fifo_flex_lfsr.sv
// Purpose: free-running 16-bit Fibonacci LFSR used to inject pseudo-random input stalls.
// Latency: output is the registered state bit 0; advances every clock, independent of traffic.
// Backpressure: none (no handshake).
// Ports: clk, nreset (sync, active-low, loads SEED), out_bit (current state bit 0).
module umi_fifo_flex_lfsr
  import umi_fifo_flex_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic clk,
  input  logic nreset,
  output logic out_bit
);

  logic [LFSR_W-1:0] state;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state <= SEED;
    end else begin
      state <= lfsr_next(state);
    end
  end

  assign out_bit = state[0];

endmodule

// File: rtl/umi_fifo_flex.sv
// Purpose: single-clock UMI FIFO, arbitrary DEPTH, occupancy/almost-full status, bypass, chaos stalls.
// Latency: 1 cycle push-to-output in FIFO mode; 0 cycles (combinational) in bypass when empty.
// Backpressure: in.ready low when full, when bypass requested, or on LFSR chaos stall; out holds while !ready.
// Ports: clk, nreset (sync active-low), bypass, chaosmode, afull_thresh (0 = flag off),
//        fifo_full/fifo_empty/fifo_almost_full/fifo_count status, umi_in (slave), umi_out (master).
module umi_fifo_flex
  import umi_fifo_flex_pkg::*;
#(
  parameter int                DW        = 128,
  parameter int                AW        = 64,
  parameter int                CW        = 32,
  parameter int                DEPTH     = 4,
  parameter int                CNTW      = $clog2(DEPTH + 1),
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            bypass,
  input  logic            chaosmode,
  input  logic [CNTW-1:0] afull_thresh,
  output logic            fifo_full,
  output logic            fifo_empty,
  output logic            fifo_almost_full,
  output logic [CNTW-1:0] fifo_count,
  umi_fifo_flex_if.slave  umi_in,
  umi_fifo_flex_if.master umi_out
);

  localparam int              PW       = CW + 2 * AW + DW;
  localparam int              PTRW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTRW-1:0] PTR_LAST = PTRW'(DEPTH - 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

  logic [PW-1:0]   mem [DEPTH];
  logic [PTRW-1:0] wrptr;
  logic [PTRW-1:0] rdptr;
  logic [CNTW-1:0] count;

  logic            lfsr_bit;
  logic            chaos_stall;
  logic            bypass_eff;
  logic            in_ready;
  logic            out_valid;
  logic            push;
  logic            pop;
  logic [PW-1:0]   in_pkt;
  logic [PW-1:0]   head_pkt;
  logic [PW-1:0]   out_pkt;

  // DEPTH need not be a power of two, so wrap on an explicit compare.
  function automatic logic [PTRW-1:0] ptr_next(input logic [PTRW-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
  endfunction

  umi_fifo_flex_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .nreset  (nreset),
    .out_bit (lfsr_bit)
  );

  assign in_pkt   = {umi_in.cmd, umi_in.dstaddr, umi_in.srcaddr, umi_in.data};
  assign head_pkt = mem[rdptr];

  always_comb begin
    fifo_empty       = (count == '0);
    fifo_full        = (count == CNT_FULL);
    fifo_almost_full = (afull_thresh != '0) && (count >= afull_thresh);
    chaos_stall      = chaosmode && lfsr_bit;
    // Pass-through only once everything already stored has drained, so a
    // bypass request can never overtake older entries.
    bypass_eff       = bypass && fifo_empty;

    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_pkt   = '0;
    if (!nreset) begin
      // Hold both sides idle while reset is asserted.
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_pkt   = '0;
    end else if (bypass_eff) begin
      in_ready  = umi_out.ready && !chaos_stall;
      out_valid = umi_in.valid && !chaos_stall;
      out_pkt   = in_pkt;
    end else begin
      // A pop while full does not free a slot this cycle: ready is purely
      // registered-state based, keeping ready off the out.ready path.
      in_ready  = !fifo_full && !bypass && !chaos_stall;
      out_valid = !fifo_empty;
      out_pkt   = out_valid ? head_pkt : '0;
    end

    push = !bypass_eff && umi_in.valid && in_ready;
    pop  = !bypass_eff && out_valid && umi_out.ready;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      wrptr <= '0;
      rdptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrptr <= ptr_next(wrptr);
      end
      if (pop) begin
        rdptr <= ptr_next(rdptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrptr] <= in_pkt;
    end
  end

  assign fifo_count      = count;
  assign umi_in.ready    = in_ready;
  assign umi_out.valid   = out_valid;
  assign umi_out.cmd     = out_pkt[PW-1 -: CW];
  assign umi_out.dstaddr = out_pkt[DW+AW +: AW];
  assign umi_out.srcaddr = out_pkt[DW +: AW];
  assign umi_out.data    = out_pkt[DW-1:0];

endmodule

// File: tb/tb_umi_fifo_flex.sv
// Purpose: randomized scoreboard bench for umi_fifo_flex (DEPTH=5) against a queue-based reference model.
// Latency: model expects 1-cycle FIFO latency and 0-cycle bypass.
// Backpressure: model predicts in.ready from occupancy, bypass and its own LFSR sequence.
module tb_umi_fifo_flex;

  localparam int DW    = 128;
  localparam int AW    = 64;
  localparam int CW    = 32;
  localparam int DEPTH = 5;
  localparam int CNTW  = $clog2(DEPTH + 1);
  localparam int PW    = CW + 2 * AW + DW;
  localparam int NPKT  = 10000;

  typedef struct packed {
    logic [CW-1:0] cmd;
    logic [AW-1:0] dst;
    logic [AW-1:0] src;
    logic [DW-1:0] data;
  } pkt_t;

  logic            clk = 1'b0;
  logic            nreset;
  logic            bypass;
  logic            chaosmode;
  logic [CNTW-1:0] afull_thresh;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_almost_full;
  logic [CNTW-1:0] fifo_count;

  umi_fifo_flex_if #(.DW(DW), .AW(AW), .CW(CW)) u_in ();
  umi_fifo_flex_if #(.DW(DW), .AW(AW), .CW(CW)) u_out ();

  umi_fifo_flex #(
    .DW    (DW),
    .AW    (AW),
    .CW    (CW),
    .DEPTH (DEPTH)
  ) u_dut (
    .clk              (clk),
    .nreset           (nreset),
    .bypass           (bypass),
    .chaosmode        (chaosmode),
    .afull_thresh     (afull_thresh),
    .fifo_full        (fifo_full),
    .fifo_empty       (fifo_empty),
    .fifo_almost_full (fifo_almost_full),
    .fifo_count       (fifo_count),
    .umi_in           (u_in),
    .umi_out          (u_out)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  pkt_t        exp_q[$];
  logic [15:0] m_lfsr = 16'hACE1;

  task automatic check(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: dut=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  // x^16+x^14+x^13+x^11, shift right, feedback into bit 15.
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic [15:0] b;
    b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 16'd1;
    return (l >> 1) | (b << 15);
  endfunction

  // Reference model + scoreboard, evaluated mid-cycle.
  always @(negedge clk) begin
    pkt_t inp;
    pkt_t outp;
    pkt_t e_pkt;
    int   cnt;
    logic blk;
    logic byp;
    logic e_ir;
    logic e_ov;
    inp  = {u_in.cmd, u_in.dstaddr, u_in.srcaddr, u_in.data};
    outp = {u_out.cmd, u_out.dstaddr, u_out.srcaddr, u_out.data};
    cnt  = exp_q.size();
    blk  = chaosmode && m_lfsr[0];
    byp  = bypass && (cnt == 0);
    if (byp) begin
      e_ir  = u_out.ready && !blk;
      e_ov  = u_in.valid && !blk;
      e_pkt = inp;
    end else begin
      e_ir  = (cnt < DEPTH) && !bypass && !blk;
      e_ov  = (cnt != 0);
      e_pkt = e_ov ? exp_q[0] : '0;
    end
    if (!nreset) begin
      e_ir  = 1'b0;
      e_ov  = 1'b0;
      e_pkt = '0;
    end
    check("in_ready",    PW'(u_in.ready),        PW'(e_ir));
    check("out_valid",   PW'(u_out.valid),       PW'(e_ov));
    check("out_payload", PW'(outp),              PW'(e_pkt));
    check("count",       PW'(fifo_count),        PW'(cnt));
    check("full",        PW'(fifo_full),         PW'(cnt == DEPTH));
    check("empty",       PW'(fifo_empty),        PW'(cnt == 0));
    check("almost_full", PW'(fifo_almost_full),
          PW'((afull_thresh != 0) && (cnt >= int'(afull_thresh))));
    if (!nreset) begin
      exp_q.delete();
      m_lfsr = 16'hACE1;
    end else begin
      if (u_in.valid && e_ir) exp_q.push_back(inp);
      if (e_ov && u_out.ready && exp_q.size() != 0) void'(exp_q.pop_front());
      m_lfsr = lfsr_step(m_lfsr);
    end
  end

  function automatic pkt_t mk(input int n);
    pkt_t p;
    p.cmd  = CW'(n);
    p.dst  = {32'hD000_0000, 32'(n)};
    p.src  = {32'h5000_0000, 32'(n)};
    p.data = DW'(n);
    return p;
  endfunction

  function automatic pkt_t rnd_pkt();
    pkt_t p;
    for (int i = 0; i < PW / 32; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  task automatic drive(input pkt_t p);
    u_in.cmd     = p.cmd;
    u_in.dstaddr = p.dst;
    u_in.srcaddr = p.src;
    u_in.data    = p.data;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one packet and hold it until accepted.
  task automatic send(input pkt_t p);
    logic acc;
    int   waited;
    drive(p);
    u_in.valid = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      acc = u_in.ready;
      @(posedge clk);
      #1;
      waited++;
      if (waited > 200) begin
        $display("FAIL send_timeout: packet not accepted after %0d cycles", waited);
        $fatal(1, "send timeout");
      end
    end while (!acc);
    u_in.valid = 1'b0;
  endtask

  task automatic wait_empty();
    int waited;
    waited = 0;
    forever begin
      @(negedge clk);
      if (fifo_empty) break;
      waited++;
      if (waited > 200) begin
        $display("FAIL drain_timeout: fifo_empty=%0d expected 1", fifo_empty);
        $fatal(1, "drain timeout");
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic acc;
    int   sent;
    int   cycles;
    nreset       = 1'b0;
    bypass       = 1'b0;
    chaosmode    = 1'b0;
    afull_thresh = '0;
    u_in.valid   = 1'b0;
    u_out.ready  = 1'b0;
    drive('0);
    tick(3);
    nreset = 1'b1;
    tick(2);

    // Reset mid-traffic, then one push that must show up a cycle later.
    for (int i = 1; i <= 3; i++) send(mk(i));
    nreset = 1'b0;
    tick(1);
    nreset = 1'b1;
    tick(1);
    u_out.ready = 1'b1;
    send(mk(50));
    tick(2);

    // Fill to full, drain, refill across the pointer wrap.
    u_out.ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(mk(i));
    u_in.valid = 1'b1;
    drive(mk(99));
    tick(2);
    u_in.valid  = 1'b0;
    u_out.ready = 1'b1;
    wait_empty();
    u_out.ready = 1'b0;
    for (int i = 6; i <= 10; i++) send(mk(i));
    u_out.ready = 1'b1;
    wait_empty();

    // Almost-full threshold, then disabled threshold.
    u_out.ready  = 1'b0;
    afull_thresh = 3'd3;
    for (int i = 11; i <= 13; i++) send(mk(i));
    tick(1);
    u_out.ready = 1'b1;
    tick(1);
    u_out.ready = 1'b0;
    tick(1);
    afull_thresh = '0;
    for (int i = 14; i <= 16; i++) send(mk(i));
    tick(1);
    u_out.ready = 1'b1;
    wait_empty();

    // Simultaneous push/pop at count 2, then pop while full.
    u_out.ready = 1'b0;
    send(mk(30));
    send(mk(31));
    u_out.ready = 1'b1;
    for (int i = 0; i < 20; i++) send(mk(100 + i));
    u_out.ready = 1'b0;
    for (int i = 0; i < 3; i++) send(mk(200 + i));
    u_out.ready = 1'b1;
    send(mk(210));
    wait_empty();

    // Bypass requested with entries held: ordering, then 0-latency pass-through.
    u_out.ready = 1'b0;
    send(mk(40));
    send(mk(41));
    bypass     = 1'b1;
    u_in.valid = 1'b1;
    drive(mk('hDEAD));
    tick(3);
    u_out.ready = 1'b1;
    send(mk('hDEAD));
    for (int i = 0; i < 4; i++) send(rnd_pkt());
    bypass = 1'b0;
    tick(2);

    // Chaos: random valid/ready/bypass/threshold, payload held until accepted.
    chaosmode = 1'b1;
    sent      = 0;
    cycles    = 0;
    while (sent < NPKT) begin
      @(negedge clk);
      acc = u_in.valid && u_in.ready;
      @(posedge clk);
      #1;
      if (acc) sent++;
      if (acc || !u_in.valid) begin
        if (sent < NPKT && $urandom_range(3) != 0) begin
          drive(rnd_pkt());
          u_in.valid = 1'b1;
        end else begin
          u_in.valid = 1'b0;
        end
      end
      u_out.ready = ($urandom_range(3) != 0);
      if ($urandom_range(63) == 0) bypass = !bypass;
      if ($urandom_range(255) == 0) afull_thresh = CNTW'($urandom_range(5));
      cycles++;
      if (cycles > 80000) begin
        $display("FAIL chaos_timeout: sent=%0d expected %0d", sent, NPKT);
        $fatal(1, "chaos timeout");
      end
    end
    u_in.valid  = 1'b0;
    bypass      = 1'b0;
    u_out.ready = 1'b1;
    wait_empty();
    chaosmode = 1'b0;
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
